// File: rtl/ntt_butterfly.sv
// ntt_butterfly: three-stage pipelined CT/GS modular butterfly for Dilithium and Kyber moduli.
// Stage 1 reduces the operands, stage 2 does the modular twiddle product, and stage 3 forms the outputs.
module ntt_butterfly #(
    parameter logic [22:0] Q_DIL   = 23'd8380417,
    parameter logic [22:0] Q_KYB   = 23'd3329,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic [22:0] twiddle_i,
    input  logic        sel_red_i,
    input  logic        sel_butterfly_i,
    output logic [22:0] a_out_o,
    output logic [22:0] b_out_o
);
    if (LATENCY != 3) begin : g_latency_check
        $error("ntt_butterfly is built as a fixed three-stage pipeline");
    end

    localparam logic [47:0] M_DIL = 48'((64'd1 << 48) / {41'd0, Q_DIL});
    localparam logic [47:0] M_KYB = 48'((64'd1 << 48) / {41'd0, Q_KYB});

    // Barrett with k=48: the quotient estimate is at most one short, so one correction suffices.
    function automatic logic [22:0] mod_q(input logic [47:0] x, input logic kyb);
        logic [22:0] q;
        logic [47:0] qh;
        logic [47:0] r;
        q  = kyb ? Q_KYB : Q_DIL;
        qh = 48'(({48'd0, x} * {48'd0, (kyb ? M_KYB : M_DIL)}) >> 48);
        r  = x - qh * {25'd0, q};
        return 23'((r >= {25'd0, q}) ? r - {25'd0, q} : r);
    endfunction

    function automatic logic [22:0] add_q(input logic [22:0] x, input logic [22:0] y, input logic [22:0] q);
        logic [23:0] s;
        s = {1'b0, x} + {1'b0, y};
        return 23'((s >= {1'b0, q}) ? s - {1'b0, q} : s);
    endfunction

    function automatic logic [22:0] sub_q(input logic [22:0] x, input logic [22:0] y, input logic [22:0] q);
        return (x >= y) ? x - y : x + q - y;
    endfunction

    logic [22:0] q_in, a_r, b_r, q2;
    logic [22:0] a1_d, a1_q, s1_d, s1_q, m1_d, m1_q, w1_d, w1_q;
    logic        red1_d, red1_q, bf1_d, bf1_q;
    logic [22:0] a2_d, a2_q, s2_d, s2_q, t2_d, t2_q;
    logic        red2_d, red2_q, bf2_d, bf2_q;
    logic [22:0] a_out_d, a_out_q, b_out_d, b_out_q;

    always_comb begin
        q_in   = sel_red_i ? Q_KYB : Q_DIL;
        a_r    = mod_q({24'd0, a_i}, sel_red_i);
        b_r    = mod_q({24'd0, b_i}, sel_red_i);
        a1_d   = a_r;
        s1_d   = add_q(a_r, b_r, q_in);
        m1_d   = sel_butterfly_i ? sub_q(a_r, b_r, q_in) : b_r;
        w1_d   = twiddle_i;
        red1_d = sel_red_i;
        bf1_d  = sel_butterfly_i;
    end

    always_comb begin
        a2_d   = a1_q;
        s2_d   = s1_q;
        t2_d   = mod_q({25'd0, m1_q} * {25'd0, w1_q}, red1_q);
        red2_d = red1_q;
        bf2_d  = bf1_q;
    end

    always_comb begin
        q2      = red2_q ? Q_KYB : Q_DIL;
        a_out_d = bf2_q ? s2_q : add_q(a2_q, t2_q, q2);
        b_out_d = bf2_q ? t2_q : sub_q(a2_q, t2_q, q2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a1_q    <= '0;
            s1_q    <= '0;
            m1_q    <= '0;
            w1_q    <= '0;
            red1_q  <= 1'b0;
            bf1_q   <= 1'b0;
            a2_q    <= '0;
            s2_q    <= '0;
            t2_q    <= '0;
            red2_q  <= 1'b0;
            bf2_q   <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            a1_q    <= a1_d;
            s1_q    <= s1_d;
            m1_q    <= m1_d;
            w1_q    <= w1_d;
            red1_q  <= red1_d;
            bf1_q   <= bf1_d;
            a2_q    <= a2_d;
            s2_q    <= s2_d;
            t2_q    <= t2_d;
            red2_q  <= red2_d;
            bf2_q   <= bf2_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign a_out_o = a_out_q;
    assign b_out_o = b_out_q;
endmodule

// File: tb/tb_ntt_butterfly.sv
// tb_ntt_butterfly: directed and random vectors for ntt_butterfly, checked against a plain-integer model.
module tb_ntt_butterfly;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] a = '0, b = '0;
    logic [22:0] w = '0;
    logic        red = 1'b0, bf = 1'b0;
    logic [22:0] a_out, b_out;
    int          checks = 0;
    int          failures = 0;
    logic [45:0] exp_q [3] = '{default: '0};

    ntt_butterfly dut (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .twiddle_i(w),
        .sel_red_i(red), .sel_butterfly_i(bf), .a_out_o(a_out), .b_out_o(b_out)
    );

    always #5 clk = ~clk;

    function automatic logic [45:0] model(input longint ma, mb, mw, input bit mred, mbf);
        longint q, t, ra, rb;
        q = mred ? 3329 : 8380417;
        if (!mbf) begin
            t  = (mb * mw) % q;
            ra = (ma + t) % q;
            rb = (((ma - t) % q) + q) % q;
        end else begin
            ra = (ma + mb) % q;
            rb = (((((ma - mb) % q) + q) % q) * mw) % q;
        end
        return {23'(ra), 23'(rb)};
    endfunction

    // Expected results travel through a three-deep delay line; reset empties it to zeros.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= '{default: '0};
        else begin
            exp_q[0] <= model(longint'(a), longint'(b), longint'(w), red, bf);
            exp_q[1] <= exp_q[0];
            exp_q[2] <= exp_q[1];
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({a_out, b_out} !== exp_q[2]) begin
            failures++;
            $display("FAIL model t=%0t got A=%0d B=%0d expected A=%0d B=%0d", $time, a_out, b_out,
                     exp_q[2][45:23], exp_q[2][22:0]);
        end
    end

    task automatic check(input string name, input logic [22:0] ea, eb);
        checks++;
        if (a_out !== ea || b_out !== eb) begin
            failures++;
            $display("FAIL %s got A=%0d B=%0d expected A=%0d B=%0d", name, a_out, b_out, ea, eb);
        end
    endtask

    task automatic drive(input logic [23:0] da, db, input logic [22:0] dw, input logic dred, dbf);
        a = da; b = db; w = dw; red = dred; bf = dbf;
    endtask

    task automatic run_vec(input string name, input logic [23:0] da, db, input logic [22:0] dw,
                           input logic dred, dbf, input logic [22:0] ea, eb);
        @(negedge clk);
        drive(da, db, dw, dred, dbf);
        repeat (3) @(negedge clk);
        check(name, ea, eb);
        if (dred) begin
            checks++;
            if (a_out[22:12] !== 11'd0 || b_out[22:12] !== 11'd0) begin
                failures++;
                $display("FAIL %s_hi got A[22:12]=%0d B[22:12]=%0d expected 0", name, a_out[22:12], b_out[22:12]);
            end
        end
    endtask

    logic [23:0] sa [4] = '{24'd5, 24'd5, 24'd100, 24'd3};
    logic [23:0] sb [4] = '{24'd3, 24'd3, 24'd2, 24'd5};
    logic [22:0] sw [4] = '{23'd2, 23'd2, 23'd17, 23'd1};
    logic        sr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        sf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [22:0] se_a [4] = '{23'd11, 23'd8, 23'd134, 23'd8};
    logic [22:0] se_b [4] = '{23'd8380416, 23'd4, 23'd66, 23'd8380415};

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", 23'd0, 23'd0);
        rst = 1'b0;
        run_vec("ct_dil", 24'd5, 24'd3, 23'd2, 1'b0, 1'b0, 23'd11, 23'd8380416);
        run_vec("gs_dil", 24'd5, 24'd3, 23'd2, 1'b0, 1'b1, 23'd8, 23'd4);
        run_vec("gs_dil_neg", 24'd3, 24'd5, 23'd1, 1'b0, 1'b1, 23'd8, 23'd8380415);
        run_vec("ct_dil_wrap", 24'd8380416, 24'd1, 23'd1, 1'b0, 1'b0, 23'd0, 23'd8380415);
        run_vec("ct_dil_big", 24'd16777215, 24'd0, 23'd0, 1'b0, 1'b0, 23'd16381, 23'd16381);
        run_vec("ct_kyb", 24'd100, 24'd2, 23'd17, 1'b1, 1'b0, 23'd134, 23'd66);
        run_vec("ct_kyb_neg", 24'd0, 24'd1, 23'd3328, 1'b1, 1'b0, 23'd3328, 23'd1);
        run_vec("ct_kyb_big", 24'd16777215, 24'd0, 23'd5, 1'b1, 1'b0, 23'd2384, 23'd2384);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) check($sformatf("stream%0d", i - 3), se_a[i-3], se_b[i-3]);
            if (i < 4) drive(sa[i], sb[i], sw[i], sr[i], sf[i]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(24'($urandom), 24'($urandom), 23'($urandom), 1'($urandom), 1'($urandom));
        end
        #2 rst = 1'b1;
        #1 check("async_reset", 23'd0, 23'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(24'd5, 24'd3, 23'd2, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_1", 23'd0, 23'd0);
        @(negedge clk);
        check("post_reset_2", 23'd0, 23'd0);
        @(negedge clk);
        check("post_reset_3", 23'd11, 23'd8380416);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            drive(24'($urandom), 24'($urandom), 23'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
